// File: rtl/axi4_stream_pkt_rr_arbiter_if.sv
// AXI4-Stream signal bundle used for the arbiter's muxed output stream.
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1,
  parameter int ID_WIDTH   = 1
);
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic [USER_WIDTH-1:0]   tuser;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [ID_WIDTH-1:0]     tid;

  modport master (output tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid,
                  input  tready);
  modport slave  (input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid,
                  output tready);
endinterface

// File: rtl/axi4_stream_pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter: one granted slave streams a whole packet
// (through tlast) to the shared master port before the next arbitration.
module axi4_stream_pkt_rr_arbiter #(
  parameter int SLAVES_CNT = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1,
  parameter int ID_WIDTH   = 1,
  parameter int PKT_MODE   = 1,
  localparam int SEL_WIDTH  = $clog2(SLAVES_CNT),
  localparam int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [SLAVES_CNT-1:0]            pkt_avail_i,
  input  logic [SLAVES_CNT-1:0]            s_tvalid_i,
  output logic [SLAVES_CNT-1:0]            s_tready_o,
  input  logic [SLAVES_CNT*DATA_WIDTH-1:0] s_tdata_i,
  input  logic [SLAVES_CNT*KEEP_WIDTH-1:0] s_tstrb_i,
  input  logic [SLAVES_CNT*KEEP_WIDTH-1:0] s_tkeep_i,
  input  logic [SLAVES_CNT-1:0]            s_tlast_i,
  input  logic [SLAVES_CNT*USER_WIDTH-1:0] s_tuser_i,
  input  logic [SLAVES_CNT*DEST_WIDTH-1:0] s_tdest_i,
  input  logic [SLAVES_CNT*ID_WIDTH-1:0]   s_tid_i,
  axi4_stream_if.master                    master_if,
  output logic [SEL_WIDTH-1:0]             grant_o,
  output logic                             busy_o
);
  localparam int SUM_W = SEL_WIDTH + 1;

  typedef enum logic {IDLE, FWD} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tstrb;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;
    logic [DEST_WIDTH-1:0] tdest;
    logic [ID_WIDTH-1:0]   tid;
  } beat_t;

  state_t               state_q, state_d;
  logic [SEL_WIDTH-1:0] grant_q, grant_d;
  logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [SLAVES_CNT-1:0] req;
  logic                 pick_valid;
  logic [SEL_WIDTH-1:0] pick_idx;
  logic [SUM_W-1:0]     cand;
  logic                 sel_valid;
  logic                 pkt_done;
  beat_t                slv [SLAVES_CNT];
  beat_t                sel;

  for (genvar g = 0; g < SLAVES_CNT; g++) begin : g_unpack
    assign slv[g] = {s_tdata_i[g*DATA_WIDTH +: DATA_WIDTH],
                     s_tstrb_i[g*KEEP_WIDTH +: KEEP_WIDTH],
                     s_tkeep_i[g*KEEP_WIDTH +: KEEP_WIDTH],
                     s_tlast_i[g],
                     s_tuser_i[g*USER_WIDTH +: USER_WIDTH],
                     s_tdest_i[g*DEST_WIDTH +: DEST_WIDTH],
                     s_tid_i[g*ID_WIDTH +: ID_WIDTH]};
  end

  assign req       = (PKT_MODE != 0) ? pkt_avail_i : s_tvalid_i;
  assign sel       = slv[grant_q];
  assign sel_valid = s_tvalid_i[grant_q];
  assign pkt_done  = (state_q == FWD) && sel_valid && master_if.tready && sel.tlast;

  // Scan upward from the rr pointer, wrapping, and keep the first requester found.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int off = 0; off < SLAVES_CNT; off++) begin
      cand = {1'b0, rr_ptr_q} + SUM_W'(off);
      if (cand >= SUM_W'(SLAVES_CNT)) cand = cand - SUM_W'(SLAVES_CNT);
      if (!pick_valid && req[cand[SEL_WIDTH-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[SEL_WIDTH-1:0];
      end
    end
  end

  assign master_if.tdata = sel.tdata;
  assign master_if.tstrb = sel.tstrb;
  assign master_if.tkeep = sel.tkeep;
  assign master_if.tlast = sel.tlast;
  assign master_if.tuser = sel.tuser;
  assign master_if.tdest = sel.tdest;
  assign master_if.tid   = sel.tid;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    state_d          = state_q;
    grant_d          = grant_q;
    rr_ptr_d         = rr_ptr_q;
    s_tready_o       = '0;
    master_if.tvalid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = FWD;
          grant_d = pick_idx;
        end
      end
      FWD: begin
        master_if.tvalid    = sel_valid;
        s_tready_o[grant_q] = master_if.tready;
        if (pkt_done) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == SEL_WIDTH'(SLAVES_CNT - 1)) ? '0 : grant_q + SEL_WIDTH'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q == FWD);
endmodule

// File: tb/tb_axi4_stream_pkt_rr_arbiter.sv
// Bench for the packet round-robin arbiter: queue-driven slave sources, a
// packet-level reference model compared every cycle, and directed literal checks.
module tb_axi4_stream_pkt_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int KW = DW / 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // main DUT (packet mode)
  logic [N-1:0]    pkt_avail, s_tvalid, s_tready, s_tlast, s_tuser, s_tdest, s_tid;
  logic [N*DW-1:0] s_tdata;
  logic [N*KW-1:0] s_tstrb, s_tkeep;
  logic [1:0]      grant;
  logic            busy;
  logic            m_tready;

  axi4_stream_if #(.DATA_WIDTH(DW)) m_if ();
  assign m_if.tready = m_tready;

  axi4_stream_pkt_rr_arbiter #(.SLAVES_CNT(N), .DATA_WIDTH(DW), .PKT_MODE(1)) dut (
    .clk_i(clk), .rst_i(rst), .pkt_avail_i(pkt_avail),
    .s_tvalid_i(s_tvalid), .s_tready_o(s_tready), .s_tdata_i(s_tdata),
    .s_tstrb_i(s_tstrb), .s_tkeep_i(s_tkeep), .s_tlast_i(s_tlast),
    .s_tuser_i(s_tuser), .s_tdest_i(s_tdest), .s_tid_i(s_tid),
    .master_if(m_if), .grant_o(grant), .busy_o(busy)
  );

  // second DUT (tvalid-request mode) driven by directed signals only
  logic [N-1:0]    z_tvalid = '0, z_tlast = '0, z_ready;
  logic [N*DW-1:0] z_tdata = '0;
  logic [1:0]      z_grant;
  logic            z_busy;

  axi4_stream_if #(.DATA_WIDTH(DW)) z_if ();
  assign z_if.tready = 1'b1;

  axi4_stream_pkt_rr_arbiter #(.SLAVES_CNT(N), .DATA_WIDTH(DW), .PKT_MODE(0)) dut_v (
    .clk_i(clk), .rst_i(rst), .pkt_avail_i('0),
    .s_tvalid_i(z_tvalid), .s_tready_o(z_ready), .s_tdata_i(z_tdata),
    .s_tstrb_i('0), .s_tkeep_i('0), .s_tlast_i(z_tlast),
    .s_tuser_i('0), .s_tdest_i('0), .s_tid_i('0),
    .master_if(z_if), .grant_o(z_grant), .busy_o(z_busy)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // slave sources
  beat_t      src_q [N][$];
  logic [N-1:0] hold = '0;

  function automatic logic [31:0] mk(input int s, input int p, input int b);
    return 32'hD000_0000 | (32'(s) << 16) | (32'(p) << 8) | 32'(b);
  endfunction

  function automatic logic [10:0] side_of(input int i);
    logic [1:0] b;
    b = 2'(i);
    return {4'(i + 1), 4'hF, b[0], b[1], ~b[0]};
  endfunction

  function automatic logic src_valid(input int i);
    return src_q[i].size() > 0 && !hold[i];
  endfunction

  function automatic logic queues_empty();
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      int np;
      logic [10:0] sd;
      np = 0;
      for (int k = 0; k < src_q[i].size(); k++) if (src_q[i][k].last) np++;
      sd = side_of(i);
      pkt_avail[i]          = (np > 0);
      s_tvalid[i]           = src_valid(i);
      s_tdata[i*DW +: DW]   = (src_q[i].size() > 0) ? src_q[i][0].data : '0;
      s_tlast[i]            = (src_q[i].size() > 0) ? src_q[i][0].last : 1'b0;
      s_tstrb[i*KW +: KW]   = sd[10:7];
      s_tkeep[i*KW +: KW]   = sd[6:3];
      s_tuser[i]            = sd[2];
      s_tdest[i]            = sd[1];
      s_tid[i]              = sd[0];
    end
  endtask

  task automatic push_pkt(input int s, input int p, input int nbeats);
    beat_t bt;
    for (int b = 0; b < nbeats; b++) begin
      bt.data = mk(s, p, b);
      bt.last = (b == nbeats - 1);
      src_q[s].push_back(bt);
    end
  endtask

  // packet-level reference model: who owns the output, who was served last
  int owner = -1;
  int last_served = N - 1;
  int last_grant = 0;

  task automatic model_reset();
    owner       = -1;
    last_served = N - 1;
    last_grant  = 0;
  endtask

  task automatic model_step();
    beat_t bt;
    logic  found;
    if (owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (last_served + k) % N;
        if (!found && pkt_avail[c]) begin
          found      = 1'b1;
          owner      = c;
          last_grant = c;
        end
      end
    end else if (src_valid(owner) && m_tready) begin
      bt = src_q[owner].pop_front();
      if (bt.last) begin
        last_served = owner;
        owner       = -1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (!rst) model_step();
    #1 drive_inputs();
  end

  // observed logs
  int    grant_log [$];
  beat_t beat_log [$];
  logic  prev_busy = 1'b0;

  always @(negedge clk) begin
    logic         exp_valid;
    logic [N-1:0] exp_ready;
    beat_t        ob;
    exp_valid = (owner >= 0) && src_valid(owner);
    exp_ready = (owner >= 0 && m_tready) ? (N'(1) << owner) : '0;
    check("busy", busy, owner >= 0);
    check("grant", grant, 64'(last_grant));
    check("m_tvalid", m_if.tvalid, exp_valid);
    check("s_tready", s_tready, exp_ready);
    if (exp_valid) begin
      check("m_tdata", m_if.tdata, src_q[owner][0].data);
      check("m_tlast", m_if.tlast, src_q[owner][0].last);
      check("m_side", {m_if.tstrb, m_if.tkeep, m_if.tuser, m_if.tdest, m_if.tid}, side_of(owner));
    end
    if (busy && !prev_busy) grant_log.push_back(int'(grant));
    if (m_if.tvalid && m_tready) begin
      ob.data = m_if.tdata;
      ob.last = m_if.tlast;
      beat_log.push_back(ob);
    end
    prev_busy = busy;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) src_q[i].delete();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    model_reset();
    flush();
    hold     = '0;
    m_tready = 1'b1;
    z_tvalid = '0;
    z_tlast  = '0;
    drive_inputs();
    repeat (2) step();
    rst = 1'b0;
    grant_log.delete();
    beat_log.delete();
  endtask

  task automatic wait_idle(input int budget, output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while ((busy || !queues_empty()) && cycles < budget);
    check("wait_idle_in_budget", busy || !queues_empty(), 1'b0);
  endtask

  task automatic check_beats(input string name, input int s, input int p, input int first, input int n);
    for (int b = 0; b < n; b++) begin
      check(name, beat_log[first+b].data, mk(s, p, b));
      check(name, beat_log[first+b].last, b == n - 1);
    end
  endtask

  initial begin
    int   cyc;
    logic tr_seq [4];
    tr_seq = '{1'b1, 1'b0, 1'b0, 1'b1};
    #1;

    // reset state, then a lone 3-beat packet on slave 2
    do_reset();
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant, 2'd0);
    check("rst_tvalid", m_if.tvalid, 1'b0);
    check("rst_tready", s_tready, 4'b0000);
    push_pkt(2, 0, 3);
    drive_inputs();
    step();
    check("t1_grant", grant, 2'd2);
    check("t1_busy", busy, 1'b1);
    repeat (3) step();
    check("t1_busy_after_last", busy, 1'b0);
    check("t1_nbeats", beat_log.size(), 3);
    if (beat_log.size() == 3) check_beats("t1_beat", 2, 0, 0, 3);

    // all four requesting, two 2-beat packets each
    do_reset();
    for (int s = 0; s < N; s++) begin
      push_pkt(s, 0, 2);
      push_pkt(s, 1, 2);
    end
    drive_inputs();
    wait_idle(100, cyc);
    check("t2_cycles", cyc, 24);
    check("t2_ngrants", grant_log.size(), 8);
    if (grant_log.size() == 8)
      for (int k = 0; k < 8; k++) check("t2_grant_order", grant_log[k], k % N);
    check("t2_nbeats", beat_log.size(), 16);
    if (beat_log.size() == 16)
      for (int k = 0; k < 8; k++) check_beats("t2_beat", k % N, k / N, 2 * k, 2);

    // master back-pressure on slave 1 mid-packet
    do_reset();
    push_pkt(1, 0, 4);
    drive_inputs();
    step();
    for (int k = 0; k < 4; k++) begin
      m_tready = tr_seq[k];
      #1;
      check("t3_tready_mirror", s_tready, m_tready ? 4'b0010 : 4'b0000);
      step();
    end
    m_tready = 1'b1;
    wait_idle(50, cyc);
    check("t3_nbeats", beat_log.size(), 4);
    if (beat_log.size() == 4) check_beats("t3_beat", 1, 0, 0, 4);

    // slave 3 granted with data late, slave 0 requests mid-packet
    do_reset();
    push_pkt(3, 0, 3);
    hold[3] = 1'b1;
    drive_inputs();
    step();
    check("t4_grant", grant, 2'd3);
    check("t4_busy", busy, 1'b1);
    check("t4_tvalid_wait", m_if.tvalid, 1'b0);
    repeat (2) step();
    push_pkt(0, 0, 1);
    hold[3] = 1'b0;
    drive_inputs();
    wait_idle(50, cyc);
    check("t4_ngrants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("t4_first", grant_log[0], 3);
      check("t4_wrap", grant_log[1], 0);
    end
    check("t4_nbeats", beat_log.size(), 4);
    if (beat_log.size() == 4) begin
      check_beats("t4_beat3", 3, 0, 0, 3);
      check_beats("t4_beat0", 0, 0, 3, 1);
    end

    // tvalid-request mode: single-beat packets on slaves 0 and 2 together
    do_reset();
    z_tvalid = 4'b0101;
    z_tlast  = 4'b0101;
    z_tdata[0*DW +: DW] = 32'h1111_0000;
    z_tdata[2*DW +: DW] = 32'h2222_0002;
    step();
    check("t5_grant0", z_grant, 2'd0);
    check("t5_busy0", z_busy, 1'b1);
    check("t5_tvalid0", z_if.tvalid, 1'b1);
    check("t5_tdata0", z_if.tdata, 32'h1111_0000);
    check("t5_ready0", z_ready, 4'b0001);
    step();
    check("t5_gap_busy", z_busy, 1'b0);
    check("t5_gap_tvalid", z_if.tvalid, 1'b0);
    check("t5_gap_grant", z_grant, 2'd0);
    z_tvalid[0] = 1'b0;
    step();
    check("t5_grant2", z_grant, 2'd2);
    check("t5_busy2", z_busy, 1'b1);
    check("t5_tdata2", z_if.tdata, 32'h2222_0002);
    check("t5_ready2", z_ready, 4'b0100);
    step();
    check("t5_done_busy", z_busy, 1'b0);
    check("t5_hold_grant", z_grant, 2'd2);
    z_tvalid[2] = 1'b0;

    // asynchronous reset in the middle of a slave-2 packet
    do_reset();
    push_pkt(2, 0, 4);
    drive_inputs();
    step();
    check("t6_grant_pre", grant, 2'd2);
    step();
    #1;
    rst = 1'b1;
    model_reset();
    flush();
    drive_inputs();
    #1;
    check("t6_tvalid", m_if.tvalid, 1'b0);
    check("t6_tready", s_tready, 4'b0000);
    check("t6_grant", grant, 2'd0);
    check("t6_busy", busy, 1'b0);
    repeat (2) step();
    rst = 1'b0;
    grant_log.delete();
    beat_log.delete();
    push_pkt(3, 0, 1);
    push_pkt(0, 0, 1);
    drive_inputs();
    wait_idle(50, cyc);
    check("t6_ngrants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("t6_first", grant_log[0], 0);
      check("t6_second", grant_log[1], 3);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/axi4_stream_pkt_rr_arbiter.md
Name: axi4_stream_pkt_rr_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one AXI4-Stream master output between SLAVES_CNT upstream packet FIFOs (axi4_stream_sc_fifo instances).
- A requester is eligible only when its FIFO holds at least one complete packet (non-zero pkts_amount, supplied as pkt_avail_i), or in PKT_MODE=0 when tvalid is high.
- Once granted, the whole packet up to tlast passes through before re-arbitration. Packets are never interleaved.

Parameters:
- SLAVES_CNT, 4, number of requesters (2..16)
- DATA_WIDTH, 32, tdata width in bits; tkeep/tstrb width = DATA_WIDTH/8
- DEST_WIDTH, 1, tdest width
- USER_WIDTH, 1, tuser width
- ID_WIDTH, 1, tid width
- PKT_MODE, 1, 1 = request is pkt_avail_i[i]; 0 = request is s_tvalid_i[i]
- SEL_WIDTH, $clog2(SLAVES_CNT), grant index width (derived, not overridden)

Ports:
- clk_i  input  1  single clock
- rst_i  input  1  asynchronous active-high reset
- pkt_avail_i  input  SLAVES_CNT  bit i = FIFO i holds at least one complete packet
- s_tvalid_i  input  SLAVES_CNT  per-slave tvalid
- s_tready_o  output  SLAVES_CNT  per-slave tready
- s_tdata_i  input  SLAVES_CNT*DATA_WIDTH  slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- s_tstrb_i, s_tkeep_i  input  SLAVES_CNT*DATA_WIDTH/8 each  packed per slave
- s_tlast_i  input  SLAVES_CNT  per-slave tlast
- s_tuser_i  input  SLAVES_CNT*USER_WIDTH  packed per slave
- s_tdest_i  input  SLAVES_CNT*DEST_WIDTH  packed per slave
- s_tid_i  input  SLAVES_CNT*ID_WIDTH  packed per slave
- master_if  axi4_stream_if.master  -  muxed output stream
- grant_o  output  SEL_WIDTH  index of the current or last granted slave
- busy_o  output  1  high while a packet transfer is in progress

Behaviour:
- Reset: FSM=IDLE, grant_o=0, rr pointer=0 so slave 0 has top priority first, busy_o=0, s_tready_o=0, master_if.tvalid=0. Reset is asynchronous: asserting it mid-packet aborts the transfer immediately. Upstream recovery of the partial packet is not this block's responsibility.
- Request vector: req = PKT_MODE ? pkt_avail_i : s_tvalid_i.
- IDLE:
  - If req is non-zero, pick the first set bit scanning from the rr pointer upward, wrapping modulo SLAVES_CNT.
  - Register the choice into grant_o and go to FWD on the next edge. Grant latency is 1 cycle from req to the first possible beat.
  - If req is zero, stay in IDLE.
- FWD (busy_o=1):
  - Master signals are a combinational mux of slave[grant_o]: tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid.
  - s_tready_o[grant_o] = master_if.tready; all other s_tready_o bits = 0.
  - On a handshake (tvalid and tready) with tlast=1: set rr pointer = grant_o+1 (wraps to 0 after SLAVES_CNT-1) and return to IDLE. The next grant therefore comes at earliest 1 cycle later; there is one dead cycle between packets.
  - Master tready low holds the state indefinitely. Slave tvalid low mid-packet also holds the state; FWD is never left without tlast.
- IDLE outputs: master_if.tvalid=0 and s_tready_o all zeros. No beat is ever accepted without a grant.
- Simultaneous requests: the rr pointer decides. Changes to req while in FWD are ignored until IDLE.
- A single-beat packet (tvalid and tlast in the first FWD cycle with tready=1) gives FWD a duration of exactly 1 cycle.
- PKT_MODE=1 with pkt_avail_i high but tvalid low: stay in FWD with tvalid=0 until data arrives. This is legal, not an error.
- Fairness: with all requesters continuously active, grants cycle 0,1,...,SLAVES_CNT-1,0. No requester waits more than SLAVES_CNT-1 packets.
- grant_o holds its value in IDLE. Its value only changes at a new grant.

Test Plan:
- Reset then pkt_avail_i=4'b0100, slave 2 sends 3 beats (tlast on the 3rd) with tready=1 -> grant_o=2 one cycle after req; 3 master beats with identical data/tlast; busy_o low the cycle after the last beat.
- All four slaves continuously requesting, 2-beat packets -> grant order 0,1,2,3,0,1; each output packet contiguous with no interleaving; dead cycle between packets.
- Slave 1 mid-packet, master tready toggled 1,0,0,1 -> no beat lost or duplicated; s_tready_o[1] mirrors tready; other s_tready_o bits stay 0 throughout.
- Slave 3 granted, pkt_avail_i[0] rises mid-packet -> slave 3 packet completes first; next grant is 0 (wrap).
- PKT_MODE=0, single-beat packets on slaves 0 and 2 simultaneously -> slave 0 first, then slave 2; each FWD lasts exactly 1 cycle.
- rst_i asserted asynchronously mid-packet (between clock edges) -> master tvalid=0, s_tready_o=0 and grant_o=0 immediately; after release, slave 0 has top priority.
